// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the multi-channel PS/2 controller.
package ps2_ctrl_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT
  } tx_state_t;

  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_UNREAD_ERR = 1;
  localparam int STAT_TX_BUSY    = 2;
  localparam int STAT_TX_PENDING = 3;
  localparam int STAT_OVERFLOW   = 4;
  localparam int STAT_INTR_EN    = 5;

  localparam int CMD_POP   = 15;
  localparam int CMD_FLUSH = 14;
  localparam int CMD_IEWR  = 13;
  localparam int CMD_IE    = 12;

  localparam logic [7:0] PS2_RESEND = 8'hFE;

endpackage

// File: rtl/ps2_channel.sv
// One PS/2 channel: RX FIFO, sticky flags, TX command FSM and interrupt.
// PS2_AUTO_RESEND_EN: an rx error while TX is idle queues a resend byte.
module ps2_channel
  import ps2_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_wr,
  input  logic [15:12] cmd,
  input  logic         tx_wr,
  input  logic [7:0]   tx_byte,
  input  logic         clr_rd,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         rx_error,
  input  logic         tx_busy,
  input  logic         tx_complete,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  output logic [7:0]   status,
  output logic [7:0]   head,
  output logic         intr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, flush, push, overflow_set, error_set, resend;
  logic          unread_error, overflow, intr_en;
  tx_state_t     state;

  assign empty        = (count == '0);
  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign pop          = cmd_wr & cmd[CMD_POP] & ~empty;
  assign flush        = cmd_wr & cmd[CMD_FLUSH];
  // A pop frees the slot in the same cycle, so full+pop+push is not an overflow.
  assign push         = rx_valid & ~rx_error & (~full | pop);
  assign overflow_set = rx_valid & ~rx_error & full & ~pop;
  assign error_set    = rx_valid & rx_error;

`ifdef PS2_AUTO_RESEND_EN
  assign resend = error_set;
`else
  assign resend = 1'b0;
`endif

  // NOTE: sequential state uses nonblocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unread_error <= 1'b0;
      overflow     <= 1'b0;
      intr_en      <= 1'b1;
    end else begin
      if (error_set)         unread_error <= 1'b1;
      else if (clr_rd)       unread_error <= 1'b0;
      if (overflow_set)      overflow <= 1'b1;
      else if (clr_rd)       overflow <= 1'b0;
      if (cmd_wr & cmd[CMD_IEWR]) intr_en <= cmd[CMD_IE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_data <= tx_byte;
            state   <= TX_REQ;
          end else if (resend) begin
            tx_data <= PS2_RESEND;
            state   <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: if (tx_complete) state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign head = empty ? 8'h00 : mem[rd_ptr];
  assign intr = intr_en & ~empty;

  // NOTE: default first so the combinational block never infers a latch.
  always_comb begin
    status                  = '0;
    status[STAT_NOT_EMPTY]  = ~empty;
    status[STAT_UNREAD_ERR] = unread_error;
    status[STAT_TX_BUSY]    = tx_busy;
    status[STAT_TX_PENDING] = (state != TX_IDLE);
    status[STAT_OVERFLOW]   = overflow;
    status[STAT_INTR_EN]    = intr_en;
  end

endmodule

// File: rtl/ps2_multi_controller.sv
// Multi-channel PS/2 controller behind a 16-bit CPU data port.
// Optional PS2_AUTO_RESEND_EN is implemented inside ps2_channel.
module ps2_multi_controller
  import ps2_ctrl_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int FIFO_DEPTH = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                data_m_access,
  input  logic                data_m_wr_en,
  input  logic [CH_W-1:0]     data_m_addr,
  output logic                data_m_ack,
  output logic [15:0]         data_m_data_out,
  input  logic [15:0]         data_m_data_in,
  input  logic [1:0]          data_m_bytesel,
  output logic [NUM_CH-1:0]   ps2_intr,
  input  logic [8*NUM_CH-1:0] rx_data,
  input  logic [NUM_CH-1:0]   rx_valid,
  input  logic [NUM_CH-1:0]   rx_error,
  output logic [8*NUM_CH-1:0] tx_data,
  output logic [NUM_CH-1:0]   tx_start,
  input  logic [NUM_CH-1:0]   tx_busy,
  input  logic [NUM_CH-1:0]   tx_complete
);

  logic        sel, rd, wr;
  logic [7:0]  status [NUM_CH];
  logic [7:0]  head   [NUM_CH];
  logic [15:0] rd_word;
  logic        unused_data;

  assign sel         = data_m_access & cs;
  assign rd          = sel & ~data_m_wr_en;
  assign wr          = sel & data_m_wr_en;
  assign unused_data = ^data_m_data_in[11:8];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = (data_m_addr == CH_W'(c));

    ps2_channel #(.FIFO_DEPTH(FIFO_DEPTH)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .cmd_wr      (wr & hit & data_m_bytesel[1]),
      .cmd         (data_m_data_in[15:12]),
      .tx_wr       (wr & hit & data_m_bytesel[0]),
      .tx_byte     (data_m_data_in[7:0]),
      .clr_rd      (rd & hit & data_m_bytesel[1]),
      .rx_data     (rx_data[8*c +: 8]),
      .rx_valid    (rx_valid[c]),
      .rx_error    (rx_error[c]),
      .tx_busy     (tx_busy[c]),
      .tx_complete (tx_complete[c]),
      .tx_data     (tx_data[8*c +: 8]),
      .tx_start    (tx_start[c]),
      .status      (status[c]),
      .head        (head[c]),
      .intr        (ps2_intr[c])
    );
  end

  // Out-of-range channel addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_m_addr == CH_W'(i)) rd_word = {status[i], head[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_m_ack      <= 1'b0;
      data_m_data_out <= '0;
    end else begin
      data_m_ack      <= sel;
      data_m_data_out <= rd ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_ps2_multi_controller.sv
// Self-checking bench for ps2_multi_controller: vector table plus bus scoreboard.
module tb_ps2_multi_controller;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
`ifdef PS2_AUTO_RESEND_EN
  localparam bit RESEND = 1'b1;
`else
  localparam bit RESEND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cs = 1'b0;
  logic                data_m_access = 1'b0;
  logic                data_m_wr_en = 1'b0;
  logic [CH_W-1:0]     data_m_addr = '0;
  logic                data_m_ack;
  logic [15:0]         data_m_data_out;
  logic [15:0]         data_m_data_in = '0;
  logic [1:0]          data_m_bytesel = '0;
  logic [NUM_CH-1:0]   ps2_intr;
  logic [8*NUM_CH-1:0] rx_data = '0;
  logic [NUM_CH-1:0]   rx_valid = '0;
  logic [NUM_CH-1:0]   rx_error = '0;
  logic [8*NUM_CH-1:0] tx_data;
  logic [NUM_CH-1:0]   tx_start;
  logic [NUM_CH-1:0]   tx_busy = '0;
  logic [NUM_CH-1:0]   tx_complete = '0;

  ps2_multi_controller #(.NUM_CH(NUM_CH), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_access   (data_m_access),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_addr     (data_m_addr),
    .data_m_ack      (data_m_ack),
    .data_m_data_out (data_m_data_out),
    .data_m_data_in  (data_m_data_in),
    .data_m_bytesel  (data_m_bytesel),
    .ps2_intr        (ps2_intr),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_error        (rx_error),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .tx_complete     (tx_complete)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          acc;
    bit          wr;
    int          ch;
    logic [1:0]  bsel;
    logic [15:0] d;
    bit          rxv;
    bit          rxe;
    int          rxch;
    logic [7:0]  rxb;
    logic [15:0] exp_rd;
    logic [1:0]  exp_intr;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          start_cnt[NUM_CH] = '{default: 0};
  logic [7:0]  last_tx[NUM_CH]   = '{default: '0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every ack pops one expected read word.
  always @(negedge clk) begin
    if (data_m_ack) begin
      if (sb.size() == 0) check("unexpected_ack", 32'(data_m_ack), 32'd0);
      else                check("read_data", 32'(data_m_data_out), 32'(sb.pop_front()));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (tx_start[c]) begin
        start_cnt[c]++;
        last_tx[c] = tx_data[8*c +: 8];
      end
    end
  end

  function automatic vec_t v_rd(int ch, logic [1:0] bs, logic [15:0] e, logic [1:0] ir);
    vec_t v = '{default: '0};
    v.acc = 1'b1; v.ch = ch; v.bsel = bs; v.exp_rd = e; v.exp_intr = ir;
    return v;
  endfunction

  function automatic vec_t v_wr(int ch, logic [1:0] bs, logic [15:0] d, logic [1:0] ir);
    vec_t v = '{default: '0};
    v.acc = 1'b1; v.wr = 1'b1; v.ch = ch; v.bsel = bs; v.d = d; v.exp_intr = ir;
    return v;
  endfunction

  function automatic vec_t with_rx(vec_t vin, int ch, logic [7:0] b, bit err);
    vec_t v = vin;
    v.rxv = 1'b1; v.rxch = ch; v.rxb = b; v.rxe = err;
    return v;
  endfunction

  function automatic vec_t v_rx(int ch, logic [7:0] b, bit err, logic [1:0] ir);
    vec_t v = '{default: '0};
    v.exp_intr = ir;
    return with_rx(v, ch, b, err);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cs             = 1'b1;
    data_m_access  = v.acc;
    data_m_wr_en   = v.wr;
    data_m_addr    = CH_W'(v.ch);
    data_m_bytesel = v.bsel;
    data_m_data_in = v.d;
    if (v.rxv) begin
      rx_valid[v.rxch]          = 1'b1;
      rx_error[v.rxch]          = v.rxe;
      rx_data[8*v.rxch +: 8]    = v.rxb;
    end
    if (v.acc) sb.push_back(v.exp_rd);
    @(negedge clk);
    #1;
    data_m_access  = 1'b0;
    data_m_wr_en   = 1'b0;
    data_m_bytesel = '0;
    data_m_data_in = '0;
    rx_valid       = '0;
    rx_error       = '0;
    if (v.acc) check("ack_latency", sb.size(), 0);
    check("intr", 32'(ps2_intr), 32'(v.exp_intr));
  endtask

  task automatic pulse_complete(input int ch);
    @(negedge clk);
    tx_complete[ch] = 1'b1;
    @(negedge clk);
    #1;
    tx_complete[ch] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    // Reset state and the basic FIFO sequences as a vector table.
    vecs.push_back(v_rd(0, 2'b00, 16'h2000, 2'b00));
    vecs.push_back(v_rx(1, 8'h1C, 1'b0, 2'b10));
    vecs.push_back(v_rx(1, 8'hF0, 1'b0, 2'b10));
    vecs.push_back(v_rd(1, 2'b00, 16'h211C, 2'b10));
    vecs.push_back(v_rd(0, 2'b00, 16'h2000, 2'b10));
    vecs.push_back(v_wr(1, 2'b10, 16'h8000, 2'b10));
    vecs.push_back(v_rd(1, 2'b00, 16'h21F0, 2'b10));
    vecs.push_back(v_wr(1, 2'b10, 16'h8000, 2'b00));
    vecs.push_back(v_rd(1, 2'b00, 16'h2000, 2'b00));
    vecs.push_back(v_wr(1, 2'b10, 16'h8000, 2'b00));
    vecs.push_back(v_rd(1, 2'b00, 16'h2000, 2'b00));
    for (int i = 0; i < 8; i++) vecs.push_back(v_rx(0, 8'(8'h10 + i), 1'b0, 2'b01));
    vecs.push_back(v_rx(0, 8'h18, 1'b0, 2'b01));
    vecs.push_back(v_rd(0, 2'b00, 16'h3110, 2'b01));
    vecs.push_back(with_rx(v_wr(0, 2'b10, 16'h8000, 2'b01), 0, 8'h19, 1'b0));
    vecs.push_back(v_rd(0, 2'b10, 16'h3111, 2'b01));
    vecs.push_back(v_rd(0, 2'b00, 16'h2111, 2'b01));
    vecs.push_back(with_rx(v_rd(0, 2'b10, 16'h2111, 2'b01), 0, 8'h1A, 1'b0));
    vecs.push_back(v_rd(0, 2'b00, 16'h3111, 2'b01));
    vecs.push_back(v_rd(0, 2'b10, 16'h3111, 2'b01));
    vecs.push_back(v_wr(0, 2'b10, 16'h4000, 2'b00));
    vecs.push_back(v_rd(0, 2'b00, 16'h2000, 2'b00));
    vecs.push_back(v_rx(0, 8'h55, 1'b0, 2'b01));
    vecs.push_back(v_wr(0, 2'b10, 16'h2000, 2'b00));
    vecs.push_back(v_rd(0, 2'b00, 16'h0155, 2'b00));
    vecs.push_back(with_rx(v_wr(0, 2'b10, 16'h4000, 2'b00), 0, 8'h66, 1'b0));
    vecs.push_back(v_rd(0, 2'b00, 16'h0000, 2'b00));
    vecs.push_back(v_wr(0, 2'b10, 16'h3000, 2'b00));
    vecs.push_back(v_rd(0, 2'b00, 16'h2000, 2'b00));
    vecs.push_back(v_rx(1, 8'h00, 1'b0, 2'b10));
    vecs.push_back(v_rd(1, 2'b00, 16'h2100, 2'b10));
    vecs.push_back(v_wr(1, 2'b10, 16'h8000, 2'b00));
    vecs.push_back(v_rd(1, 2'b00, 16'h2000, 2'b00));

    idle(3);
    check("reset_ack", 32'(data_m_ack), 32'd0);
    check("reset_data_out", 32'(data_m_data_out), 32'd0);
    check("reset_intr", 32'(ps2_intr), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // An access without chip select is not acknowledged and does nothing.
    @(negedge clk);
    cs = 1'b0; data_m_access = 1'b1; data_m_wr_en = 1'b1;
    data_m_bytesel = 2'b01; data_m_data_in = 16'h00AA;
    @(negedge clk);
    #1;
    check("no_ack_without_cs", 32'(data_m_ack), 32'd0);
    data_m_access = 1'b0; data_m_wr_en = 1'b0; data_m_bytesel = '0; data_m_data_in = '0;
    apply(v_rd(0, 2'b00, 16'h2000, 2'b00));

    // TX command held off by tx_busy, one start pulse, second write ignored.
    base = start_cnt[0];
    tx_busy[0] = 1'b1;
    apply(v_wr(0, 2'b01, 16'h00ED, 2'b00));
    apply(v_rd(0, 2'b00, 16'h2C00, 2'b00));
    check("tx_start_held_while_busy", start_cnt[0] - base, 0);
    tx_busy[0] = 1'b0;
    n = 0;
    while (start_cnt[0] == base && n < 10) begin
      @(negedge clk);
      n++;
    end
    idle(3);
    check("tx_start_once", start_cnt[0] - base, 1);
    check("tx_data_at_start", 32'(last_tx[0]), 32'h0000_00ED);
    apply(v_wr(0, 2'b01, 16'h0055, 2'b00));
    idle(3);
    check("write_in_wait_ignored", start_cnt[0] - base, 1);
    check("tx_data_kept", 32'(tx_data[7:0]), 32'h0000_00ED);
    apply(v_rd(0, 2'b00, 16'h2800, 2'b00));
    pulse_complete(0);
    apply(v_rd(0, 2'b00, 16'h2000, 2'b00));

    // RX error: sticky flag, FIFO untouched, optional auto resend.
    base = start_cnt[1];
    apply(v_rx(1, 8'h77, 1'b1, 2'b00));
    apply(v_rd(1, 2'b00, RESEND ? 16'h2A00 : 16'h2200, 2'b00));
    idle(3);
    check("resend_start", start_cnt[1] - base, RESEND ? 1 : 0);
    check("resend_data", 32'(tx_data[15:8]), RESEND ? 32'h0000_00FE : 32'h0);
    pulse_complete(1);
    apply(v_rd(1, 2'b10, 16'h2200, 2'b00));
    apply(v_rd(1, 2'b00, 16'h2000, 2'b00));

    // Reset while a TX request is pending.
    base = start_cnt[1];
    tx_busy[1] = 1'b1;
    apply(v_wr(1, 2'b01, 16'h0012, 2'b00));
    apply(v_rx(0, 8'h33, 1'b0, 2'b01));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_tx_start", 32'(tx_start), 32'd0);
    check("midreset_intr", 32'(ps2_intr), 32'd0);
    check("midreset_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tx_busy = '0;
    idle(4);
    check("no_start_after_reset", start_cnt[1] - base, 0);
    apply(v_rd(1, 2'b00, 16'h2000, 2'b00));
    apply(v_rd(0, 2'b00, 16'h2000, 2'b00));

    idle(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
